// File: rtl/spad_resource_arbiter_pkg.sv
// Shared types for the scratchpad SRAM/crossbar reservation arbiter.
// Holds the FSM and owner encodings, requester indices and a owner-to-grant helper.
package spad_resource_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BE   = 2'd1,
    OWN_VC   = 2'd2,
    OWN_SA   = 2'd3
  } owner_t;

  localparam int REQ_BE  = 0;
  localparam int REQ_VC  = 1;
  localparam int REQ_SA  = 2;
  localparam int NUM_REQ = 3;

  function automatic logic [NUM_REQ-1:0] owner_onehot(owner_t o);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    case (o)
      OWN_BE:  oh[REQ_BE] = 1'b1;
      OWN_VC:  oh[REQ_VC] = 1'b1;
      OWN_SA:  oh[REQ_SA] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/spad_resource_arbiter_if.sv
// Request/release/grant bundle between the three scratchpad requesters and the arbiter.
// The master side is the requester group, the slave side is the arbiter.
interface spad_resource_arbiter_if;
  import spad_resource_arbiter_pkg::*;

  logic   req_be;
  logic   req_vc;
  logic   req_sa;
  logic   rel_be;
  logic   rel_vc;
  logic   rel_sa;
  logic   gnt_be;
  logic   gnt_vc;
  logic   gnt_sa;
  owner_t owner;
  logic   busy;
  logic   timeout;

  modport master (
    output req_be, req_vc, req_sa, rel_be, rel_vc, rel_sa,
    input  gnt_be, gnt_vc, gnt_sa, owner, busy, timeout
  );

  modport slave (
    input  req_be, req_vc, req_sa, rel_be, rel_vc, rel_sa,
    output gnt_be, gnt_vc, gnt_sa, owner, busy, timeout
  );

endinterface

// File: rtl/spad_resource_arbiter_age_counter.sv
// Saturating wait counter: counts cycles a requester has waited, flags when the
// limit is reached so the arbiter can promote it above the fixed priority.
module spad_age_counter #(
  parameter int AGE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age;

  assign sat = (age == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      age <= '0;
    end else if (inc && !sat) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/spad_resource_arbiter.sv
// Reservation arbiter for the shared scratchpad SRAM port and crossbar (BE > VC > SA,
// with aging for VC/SA and a bounded hold). All outputs come straight from flops.
module spad_resource_arbiter
  import spad_resource_arbiter_pkg::*;
#(
  parameter int MAX_HOLD  = 16,
  parameter int AGE_LIMIT = 8
) (
  input logic                   clk,
  input logic                   rst,
  spad_resource_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t         state, state_nxt;
  owner_t             owner_q, owner_nxt, winner;
  logic [NUM_REQ-1:0] gnt_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               busy_q, timeout_q, timeout_nxt;
  logic               grant_take;

  logic [NUM_REQ-1:0] req, rel;
  logic               own_req, own_rel, hold_max;
  logic               sat_vc, sat_sa, inc_vc, inc_sa, clr_vc, clr_sa;

  assign req = {bus.req_sa, bus.req_vc, bus.req_be};
  assign rel = {bus.rel_sa, bus.rel_vc, bus.rel_be};

  // Masking with the current grant makes releases from non-owners invisible.
  assign own_req  = |(req & gnt_q);
  assign own_rel  = |(rel & gnt_q);
  assign hold_max = (hold_cnt == HOLD_LAST);

  always_comb begin
    winner = OWN_NONE;
    if (sat_vc && req[REQ_VC])      winner = OWN_VC;
    else if (sat_sa && req[REQ_SA]) winner = OWN_SA;
    else if (req[REQ_BE])           winner = OWN_BE;
    else if (req[REQ_VC])           winner = OWN_VC;
    else if (req[REQ_SA])           winner = OWN_SA;
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner_q;
    timeout_nxt = 1'b0;
    grant_take  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt  = GRANT;
          owner_nxt  = winner;
          grant_take = 1'b1;
        end
      end
      GRANT: begin
        if (own_rel || !own_req || hold_max) begin
          state_nxt   = TURN;
          owner_nxt   = OWN_NONE;
          // A release or dropped request on the last cycle wins over the forced revoke.
          timeout_nxt = hold_max && !own_rel && own_req;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= OWN_NONE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      owner_q   <= owner_nxt;
      gnt_q     <= owner_onehot(owner_nxt);
      busy_q    <= (state_nxt != IDLE);
      timeout_q <= timeout_nxt;
      if (grant_take) begin
        hold_cnt <= '0;
      end else if (state == GRANT && !hold_max) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign inc_vc = req[REQ_VC] && (owner_q != OWN_VC);
  assign inc_sa = req[REQ_SA] && (owner_q != OWN_SA);
  assign clr_vc = !req[REQ_VC] || (grant_take && winner == OWN_VC);
  assign clr_sa = !req[REQ_SA] || (grant_take && winner == OWN_SA);

  spad_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_vc (
    .clk (clk),
    .rst (rst),
    .inc (inc_vc),
    .clr (clr_vc),
    .sat (sat_vc)
  );

  spad_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_sa (
    .clk (clk),
    .rst (rst),
    .inc (inc_sa),
    .clr (clr_sa),
    .sat (sat_sa)
  );

  assign bus.gnt_be  = gnt_q[REQ_BE];
  assign bus.gnt_vc  = gnt_q[REQ_VC];
  assign bus.gnt_sa  = gnt_q[REQ_SA];
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
